// File: rtl/stage_reg_rr_arbiter_if.sv
// stage_reg_rr_arbiter_if: requester-side and consumer-side handshake bundle
// for the round-robin staging register.
interface stage_reg_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 63,
    parameter int SRCW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  flush;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SRCW-1:0]       out_src;
    logic                  out_ready;
    logic [15:0]           drop_cnt;

    modport master (
        output req_valid, req_data, flush, out_ready,
        input  req_ready, out_valid, out_data, out_src, drop_cnt
    );
    modport slave (
        input  req_valid, req_data, flush, out_ready,
        output req_ready, out_valid, out_data, out_src, drop_cnt
    );
endinterface

// File: rtl/stage_reg_rr_arbiter.sv
// stage_reg_rr_arbiter: one WIDTH-bit staging register shared by NREQ producers,
// loaded under round-robin arbitration and drained with valid/ready.
module stage_reg_rr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 63,
    localparam int SRCW  = $clog2(NREQ)
) (
    input logic clk,
    input logic rst,
    stage_reg_rr_arbiter_if.slave s
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [SRCW-1:0] rr_ptr, grant, src_q;
    logic [WIDTH-1:0] data_q;
    logic [15:0]     drop_q;
    logic            can_load, accept, pop, drop;

    // Scan from highest to lowest offset so the closest requester after rr_ptr wins.
    always_comb begin : grant_search
        int idx;
        grant = rr_ptr;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (s.req_valid[idx]) grant = SRCW'(idx);
        end
    end

    assign can_load = !rst && !s.flush && (state == EMPTY || s.out_ready);
    assign accept   = can_load && |s.req_valid;
    assign pop      = state == FULL && s.out_ready;
    assign drop     = s.flush && state == FULL && !s.out_ready;

    always_comb begin
        state_nxt = state;
        state_nxt = s.flush ? EMPTY : accept ? FULL : pop ? EMPTY : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= '0;
            drop_q <= '0;
        end else begin
            if (accept) begin
                data_q <= s.req_data[int'(grant)*WIDTH +: WIDTH];
                src_q  <= grant;
                rr_ptr <= (grant == SRCW'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
            if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign s.req_ready = accept ? NREQ'(1) << grant : '0;
    assign s.out_valid = state == FULL;
    assign s.out_data  = data_q;
    assign s.out_src   = src_q;
    assign s.drop_cnt  = drop_q;
endmodule

// File: tb/tb_stage_reg_rr_arbiter.sv
// tb_stage_reg_rr_arbiter: directed stimulus with expected grants; a monitor
// scores every popped entry against a queue of expected payload/source pairs.
module tb_stage_reg_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 63;
    localparam int SRCW  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SRCW-1:0]  s;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_reg_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    stage_reg_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .s(bus));

    int errors = 0;
    int checks = 0;
    ent_t q[$];
    ent_t mon_e;
    logic [WIDTH-1:0] base;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_pop", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("pop_data", 64'(bus.out_data), 64'(mon_e.d));
                chk("pop_src", 64'(bus.out_src), 64'(mon_e.s));
            end
        end
    end

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    endtask

    // Apply one cycle of stimulus, check the grant, record the expected entry.
    task automatic step(input logic [NREQ-1:0] rv, input logic ordy, input logic fl,
                        input logic [NREQ-1:0] exp_rr, input string n);
        bus.req_valid = rv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        drive_data();
        @(negedge clk);
        chk(n, 64'(bus.req_ready), 64'(exp_rr));
        for (int i = 0; i < NREQ; i++)
            if (exp_rr[i]) q.push_back('{d: base + WIDTH'(i), s: SRCW'(i)});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        base = '0;
        bus.req_valid = '1;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_src", 64'(bus.out_src), 64'd0);
        chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        rst = 1'b0;

        // single request from requester 2
        base = 63'h1232;
        step(4'b0100, 1'b1, 1'b0, 4'b0100, "t1_grant");
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_data", 64'(bus.out_data), 64'h1234);
        chk("t1_out_src", 64'(bus.out_src), 64'd2);
        step(4'b0000, 1'b1, 1'b0, 4'b0000, "t1_idle");
        chk("t1_empty", 64'(bus.out_valid), 64'd0);

        // round robin over all requesters from a fresh pointer
        pulse_reset();
        base = 63'h100;
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 1'b0, 4'(1 << (k % 4)), "t2_rr");
            chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        end

        // backpressure: hold src 1, then requester 3 wins on release
        base = 63'h300;
        step(4'b0010, 1'b1, 1'b0, 4'b0010, "t3_load");
        for (int k = 0; k < 5; k++) begin
            step(4'b1001, 1'b0, 1'b0, 4'b0000, "t3_stall");
            chk("t3_hold_data", 64'(bus.out_data), 64'h301);
            chk("t3_hold_src", 64'(bus.out_src), 64'd1);
        end
        step(4'b1001, 1'b1, 1'b0, 4'b1000, "t3_release");

        // flush while stalled drops; flush while ready pops
        step(4'b0000, 1'b0, 1'b1, 4'b0000, "t4_flush");
        void'(q.pop_front());
        chk("t4_valid", 64'(bus.out_valid), 64'd0);
        chk("t4_drop1", 64'(bus.drop_cnt), 64'd1);
        step(4'b1001, 1'b1, 1'b0, 4'b0001, "t4_after_flush");
        step(4'b0000, 1'b1, 1'b1, 4'b0000, "t4_flush_pop");
        chk("t4_no_drop", 64'(bus.drop_cnt), 64'd1);
        chk("t4_valid2", 64'(bus.out_valid), 64'd0);
        step(4'b0100, 1'b1, 1'b0, 4'b0100, "t4_load2");
        step(4'b0011, 1'b0, 1'b1, 4'b0000, "t4_flush_reqs");
        void'(q.pop_front());
        chk("t4_drop2", 64'(bus.drop_cnt), 64'd2);
        step(4'b0011, 1'b1, 1'b0, 4'b0001, "t4_rr_kept");

        // saturation: preload near the top, then drop past it
        force dut.drop_q = 16'hFFFD;
        #1;
        release dut.drop_q;
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b1, 1'b0, 4'b0001, "t5_load");
            step(4'b0000, 1'b0, 1'b1, 4'b0000, "t5_flush");
            void'(q.pop_front());
            if (k >= 1) chk("t5_sat", 64'(bus.drop_cnt), 64'hFFFF);
        end

        // reset with a held entry and pending requests
        step(4'b0110, 1'b0, 1'b0, 4'b0010, "t6_load");
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_drop", 64'(bus.drop_cnt), 64'd0);
        step(4'b0110, 1'b1, 1'b0, 4'b0010, "t6_first_grant");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, "t6_drain");
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
